// File: rtl/tia_playfield_serializer.sv
// TIA playfield block: CPU-written 20-bit playfield shifted out one bit per hclk_en, repeat/reflect at centre.
// Optional probe outputs pf_pos/pf_active are compiled in when TIA_PF_DEBUG_EN is defined.
module tia_playfield_serializer #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clkp,
  input  logic       reset_bar,
  input  logic       hclk_en,
  input  logic       rhb,
  input  logic       cnt,
  input  logic       ref_bar,
  input  logic [7:0] d,
  input  logic       pf0_we,
  input  logic       pf1_we,
  input  logic       pf2_we,
`ifdef TIA_PF_DEBUG_EN
  output logic [4:0] pf_pos,
  output logic       pf_active,
`endif
  output logic       cntd,
  output logic       pf
);

  localparam logic [4:0] LAST_IDX = 5'd19;

  logic [3:0]  pf0r;
  logic [7:0]  pf1r;
  logic [7:0]  pf2r;
  logic [19:0] playfield;
  logic [4:0]  pos;
  logic [4:0]  pos_nxt;
  logic        dir;      // 0 = forward, 1 = reverse
  logic        dir_nxt;
  logic        active;
  logic        active_nxt;
  logic        at_end;
  logic        bit_sel;
  logic        bit_q;

  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      pf0r <= '0;
      pf1r <= '0;
      pf2r <= '0;
    end else begin
      if (pf0_we) pf0r <= d[7:4];
      if (pf1_we) pf1r <= d;
      if (pf2_we) pf2r <= d;
    end
  end

  // Beam order: PF0 low-to-high, PF1 high-to-low, PF2 low-to-high.
  always_comb begin
    playfield = '0;
    for (int i = 0; i < 4; i++) playfield[i] = pf0r[i];
    for (int i = 0; i < 8; i++) begin
      playfield[4 + i]  = pf1r[7 - i];
      playfield[12 + i] = pf2r[i];
    end
  end

  always_ff @(posedge clkp or negedge reset_bar) begin
    if (!reset_bar) begin
      pos    <= '0;
      dir    <= 1'b0;
      active <= 1'b0;
      bit_q  <= 1'b0;
      cntd   <= 1'b0;
    end else if (hclk_en) begin
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      active <= active_nxt;
      bit_q  <= bit_sel;
      cntd   <= cnt;
    end
  end

  assign at_end = dir ? (pos == 5'd0) : (pos == LAST_IDX);

  // rhb outranks cnt; ref_bar only matters on the cnt strobe itself.
  always_comb begin
    pos_nxt    = pos;
    dir_nxt    = dir;
    active_nxt = active;
    if (rhb || (cnt && ref_bar)) begin
      pos_nxt    = '0;
      dir_nxt    = 1'b0;
      active_nxt = 1'b1;
    end else if (cnt) begin
      pos_nxt    = LAST_IDX;
      dir_nxt    = 1'b1;
      active_nxt = 1'b1;
    end else if (active) begin
      if (at_end)   active_nxt = 1'b0;
      else if (dir) pos_nxt    = pos - 5'd1;
      else          pos_nxt    = pos + 5'd1;
    end
  end

  always_comb begin
    bit_sel = active & playfield[pos];
  end

  generate
    if (OUT_REG) begin : g_out_reg
      always_ff @(posedge clkp or negedge reset_bar) begin
        if (!reset_bar) pf <= 1'b0;
        else            pf <= bit_q;
      end
    end else begin : g_out_comb
      assign pf = bit_q;
    end
  endgenerate

`ifdef TIA_PF_DEBUG_EN
  assign pf_pos    = pos;
  assign pf_active = active;
`endif

endmodule

// File: tb/tb_tia_playfield_serializer.sv
// Directed bench: table of half-line scans plus hand sequences for reset, full line, cntd, mid-scan write/reset.
module tb_tia_playfield_serializer;

  logic       clkp = 1'b0;
  logic       reset_bar;
  logic       hclk_en;
  logic       rhb;
  logic       cnt;
  logic       ref_bar;
  logic [7:0] d;
  logic       pf0_we, pf1_we, pf2_we;
  logic       cntd;
  logic       pf;
`ifdef TIA_PF_DEBUG_EN
  logic [4:0] pf_pos;
  logic       pf_active;
`endif

  tia_playfield_serializer dut (
    .clkp      (clkp),
    .reset_bar (reset_bar),
    .hclk_en   (hclk_en),
    .rhb       (rhb),
    .cnt       (cnt),
    .ref_bar   (ref_bar),
    .d         (d),
    .pf0_we    (pf0_we),
    .pf1_we    (pf1_we),
    .pf2_we    (pf2_we),
`ifdef TIA_PF_DEBUG_EN
    .pf_pos    (pf_pos),
    .pf_active (pf_active),
`endif
    .cntd      (cntd),
    .pf        (pf)
  );

  always #5 clkp = ~clkp;

  int n_vec = 0;
  int n_bad = 0;
  int hi_cnt = 0;

  typedef struct packed {
    logic [7:0]  pf0;
    logic [7:0]  pf1;
    logic [7:0]  pf2;
    logic        use_rhb;
    logic        use_cnt;
    logic        refb;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] we, input logic [7:0] dd);
    d = dd;
    {pf2_we, pf1_we, pf0_we} = we;
    @(negedge clkp);
    {pf2_we, pf1_we, pf0_we} = 3'b000;
  endtask

  // One bit time: hclk_en on the first of 4 clkp; sample taken one clkp after the hclk edge.
  task automatic hstep(input logic r, input logic c, input logic rb,
                       input logic [2:0] we, input logic [7:0] dd,
                       output logic pf_s, output logic cntd_s);
    hclk_en = 1'b1; rhb = r; cnt = c; ref_bar = rb;
    {pf2_we, pf1_we, pf0_we} = we; d = dd;
    @(negedge clkp);
    hi_cnt += int'(pf);
    hclk_en = 1'b0; rhb = 1'b0; cnt = 1'b0;
    {pf2_we, pf1_we, pf0_we} = 3'b000;
    @(negedge clkp);
    hi_cnt += int'(pf);
    pf_s = pf; cntd_s = cntd;
    @(negedge clkp);
    hi_cnt += int'(pf);
    @(negedge clkp);
    hi_cnt += int'(pf);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        s, c;
    logic [20:0] got;
    logic [40:0] line;

    //               pf0    pf1    pf2    rhb cnt ref  expected bit-time pattern
    vecs[0] = {8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 20'h00001};
    vecs[1] = {8'h00, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 20'h80010};
    vecs[2] = {8'h00, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 20'h80010};
    vecs[3] = {8'h00, 8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 20'h08001};
    vecs[4] = {8'hA0, 8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 20'h0180A};
    vecs[5] = {8'hA0, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 20'h50180};
    vecs[6] = {8'hF0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 20'hFFFFF};
    vecs[7] = {8'h0F, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 20'h00000};
    vecs[8] = {8'hA0, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0, 20'h0180A};

    // Reset with random inputs toggling
    reset_bar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hclk_en = 1'($urandom); rhb = 1'($urandom); cnt = 1'($urandom);
      ref_bar = 1'($urandom); d = 8'($urandom);
      {pf2_we, pf1_we, pf0_we} = 3'($urandom);
      @(negedge clkp);
      check($sformatf("reset_pf_%0d", i), 64'(pf), 64'd0);
      check($sformatf("reset_cntd_%0d", i), 64'(cntd), 64'd0);
    end
    hclk_en = 1'b0; rhb = 1'b0; cnt = 1'b0; ref_bar = 1'b1; d = '0;
    {pf2_we, pf1_we, pf0_we} = 3'b000;
    reset_bar = 1'b1;
    @(negedge clkp);

    // No rhb yet: output stays dark for 200 clkp even with register traffic
    hi_cnt = 0;
    for (int i = 0; i < 50; i++) hstep(1'b0, 1'b0, 1'b1, 3'($urandom), 8'($urandom), s, c);
    check("idle_before_rhb", 64'(hi_cnt), 64'd0);

    // Table-driven half-line scans
    for (int v = 0; v < 9; v++) begin
      wr(3'b001, vecs[v].pf0);
      wr(3'b010, vecs[v].pf1);
      wr(3'b100, vecs[v].pf2);
      hi_cnt = 0;
      hstep(vecs[v].use_rhb, vecs[v].use_cnt, vecs[v].refb, 3'b000, 8'h00, s, c);
      check($sformatf("vec%0d_cntd", v), 64'(c), 64'(vecs[v].use_cnt));
      for (int j = 0; j < 21; j++) begin
        hstep(1'b0, 1'b0, vecs[v].refb, 3'b000, 8'h00, s, c);
        got[j] = s;
      end
      check($sformatf("vec%0d_scan", v), 64'(got), 64'({1'b0, vecs[v].exp}));
      check($sformatf("vec%0d_hiclk", v), 64'(hi_cnt), 64'(4 * $countones(vecs[v].exp)));
    end

    // Full line: rhb, cnt 20 bit times later; ref_bar flipped mid right half has no effect
    wr(3'b001, 8'h00);
    wr(3'b010, 8'h80);
    wr(3'b100, 8'h80);
    for (int k = 0; k < 2; k++) begin
      logic rb;
      rb = (k == 0);
      hstep(1'b1, 1'b0, rb, 3'b000, 8'h00, s, c);
      for (int j = 1; j <= 41; j++) begin
        hstep(1'b0, (j == 20), (j <= 20) ? rb : ~rb, 3'b000, 8'h00, s, c);
        line[j-1] = s;
      end
      check($sformatf("line_ref_bar%0d", rb), 64'(line),
            rb ? 64'({1'b0, 20'h80010, 20'h80010}) : 64'({1'b0, 20'h08001, 20'h80010}));
    end

    // cntd follows cnt, one hclk_en at a time
    hstep(1'b0, 1'b1, 1'b1, 3'b000, 8'h00, s, c);
    check("cntd_rise", 64'(c), 64'd1);
    hstep(1'b0, 1'b1, 1'b1, 3'b000, 8'h00, s, c);
    check("cntd_hold", 64'(c), 64'd1);
    hstep(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    check("cntd_fall", 64'(c), 64'd0);
    for (int j = 0; j < 20; j++) hstep(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, s, c);

    // Mid-scan write of PF2 = 0xFF around pos 10
    wr(3'b111, 8'h00);
    hstep(1'b1, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    for (int j = 1; j <= 21; j++) begin
      hstep(1'b0, 1'b0, 1'b1, (j == 10) ? 3'b100 : 3'b000, 8'hFF, s, c);
      got[j-1] = s;
    end
    check("midscan_write", 64'(got), 64'({1'b0, 20'hFF000}));

    // Asynchronous reset mid-scan, right after a cnt strobe
    wr(3'b111, 8'hFF);
    hstep(1'b1, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    for (int j = 0; j < 5; j++) hstep(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    hstep(1'b0, 1'b1, 1'b1, 3'b000, 8'h00, s, c);
    check("pre_reset_pf", 64'(s), 64'd1);
    #2 reset_bar = 1'b0;
    #1;
    check("async_reset_pf", 64'(pf), 64'd0);
    check("async_reset_cntd", 64'(cntd), 64'd0);
    @(negedge clkp);
    reset_bar = 1'b1;
    @(negedge clkp);
    hi_cnt = 0;
    for (int j = 0; j < 25; j++) hstep(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    check("post_reset_idle", 64'(hi_cnt), 64'd0);
    hi_cnt = 0;
    hstep(1'b1, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    for (int j = 0; j < 21; j++) hstep(1'b0, 1'b0, 1'b1, 3'b000, 8'h00, s, c);
    check("post_reset_regs_clear", 64'(hi_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
